mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store alignment stage between the pipeline MEM stage and the word-only DataMem.
- Lets the pipeline issue byte, halfword and word loads and stores (lb/lbu/lh/lhu/lw/sb/sh/sw) against a memory that reads and writes only whole aligned words.
- Subword stores use a two-cycle read-modify-write and stall the pipeline for one cycle.
- Misaligned accesses are flagged and suppressed.

Parameters:
- BIG_ENDIAN, 0: byte-lane order. 0 means byte at addr[1:0]=0 is bits 7:0. 1 means byte at addr[1:0]=0 is bits 31:24.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mem_rd  in  1  pipeline load request
- mem_wr  in  1  pipeline store request
- mem_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- mem_signed  in  1  sign-extend subword loads when 1, zero-extend when 0
- addr  in  32  byte address
- wdata  in  32  store data, right-justified for subword stores
- rdata  out  32  aligned, extended load result
- stall  out  1  pipeline must hold the MEM-stage inputs this cycle
- misalign  out  1  access is misaligned; access is suppressed
- dm_rd  out  1  DataMem read enable
- dm_wr  out  1  DataMem write enable
- dm_addr  out  32  addr with bits [1:0] forced to 0
- dm_wdata  out  32  word written to DataMem
- dm_rdata  in  32  DataMem combinational read data

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset values: FSM in IDLE, merge register 0. All outputs derive combinationally from IDLE: with no request, stall=0, dm_wr=0, dm_rd=0, rdata=0, misalign=0.
- Misalignment:
  - misalign=1 when (mem_rd|mem_wr) and the access is misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - While misalign=1: dm_rd=0, dm_wr=0, rdata=0, stall=0, FSM stays IDLE.
- Request priority: mem_wr has priority when mem_rd and mem_wr are both 1; treat as a store and ignore the read.
- Loads (IDLE, mem_rd, aligned):
  - dm_rd=1; zero latency, rdata is combinational from dm_rdata.
  - Lane select: byte lane = addr[1:0], halfword lane = addr[1], mapped per BIG_ENDIAN.
  - Extension: mem_signed=1 sign-extends from bit 7 (byte) or bit 15 (halfword); otherwise zero-extends.
  - Word loads pass dm_rdata unchanged.
  - stall=0.
- Word stores (IDLE, mem_wr, size word, aligned): dm_wr=1, dm_wdata=wdata, single cycle, stall=0.
- Subword stores, two-state FSM IDLE -> MERGE_WR -> IDLE:
  - IDLE cycle:
    - Outputs: dm_rd=1, stall=1.
    - Merge: the selected lane(s) of dm_rdata are replaced with wdata[7:0] or wdata[15:0].
    - Capture: on the clock edge the merged word and the word address are registered; next state MERGE_WR.
  - MERGE_WR cycle:
    - Outputs: dm_wr=1, dm_addr=registered address, dm_wdata=merge register, dm_rd=0, stall=0, rdata=0.
    - Next state IDLE. The pipeline advances at this edge.
  - Inputs during MERGE_WR are ignored; the pipeline guarantees they are unchanged.
- Reset mid-operation: reset asserted in MERGE_WR returns the FSM to IDLE immediately. No write is issued and the partial merge is discarded.
- Address range: out-of-range addresses are forwarded unchanged; DataMem ignores the write and returns 0. For a subword store this means a merge over 0 and then an ignored write.
- Back-to-back subword stores: each takes 2 cycles; throughput is 1 store per 2 cycles.

Decomposition:
- Shared package/header, constants:
  - SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10
  - state encodings ST_IDLE, ST_MERGE_WR
- One natural sub-module: mem_lane_align. It is combinational and holds lane extraction plus sign/zero extension for loads and lane merge for stores, parameterised by BIG_ENDIAN.
- The top holds the FSM and the registers.

Test Plan:
- sw 0x11223344 to addr 0x10 -> one cycle dm_wr=1, dm_addr=0x10, stall=0. Then lw 0x10 -> rdata=0x11223344.
- Memory word 0x11223344 at 0x10, BIG_ENDIAN=0:
  - lb 0x13 -> rdata=0x00000011
  - lbu 0x10 -> rdata=0x00000044
  - lh 0x12 (signed) over memory 0x80FF0000 -> rdata=0xFFFF80FF
- sb 0xAB to 0x11 over 0x11223344 -> cycle 1 stall=1 and dm_rd=1; cycle 2 dm_wr=1 with dm_wdata=0x1122AB44. Subsequent lw -> 0x1122AB44.
- Misaligned accesses:
  - sh to 0x11 -> misalign=1, dm_wr=0 for all cycles, memory unchanged.
  - lw from 0x12 -> misalign=1, rdata=0.
- reset deasserted-to-asserted (driven low) during MERGE_WR of sh 0xBEEF to 0x20 -> no dm_wr pulse, FSM IDLE, stall=0. Memory at 0x20 unchanged after reset release.
- Two consecutive sb (0x01 to 0x30, then 0x02 to 0x31) -> 4 cycles, stall pattern 1,0,1,0, final word at 0x30 has bytes [15:0]=0x0201.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared constants, state encoding and small decode helpers for the
// load/store alignment stage.
package mem_access_unit_pkg;

    // Access size encodings as issued by the MEM stage (2'b11 behaves as word)
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Subword stores walk IDLE -> MERGE_WR -> IDLE
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MERGE_WR = 1'b1
    } state_t;

    // Halfwords need addr[0]=0, words (and the reserved size) need addr[1:0]=0
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic result;
        case (size)
            SIZE_BYTE: result = 1'b0;
            SIZE_HALF: result = addr_lo[0];
            default:   result = |addr_lo;
        endcase
        return result;
    endfunction

    // Only byte and halfword accesses need lane handling / read-modify-write
    function automatic logic is_subword(input logic [1:0] size);
        return (size == SIZE_BYTE) || (size == SIZE_HALF);
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane logic: extracts and extends the addressed byte/halfword
// of a loaded word, and merges store data into the addressed lane(s) of a
// read word. Lane order is selected by BIG_ENDIAN.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    // Physical byte lane (bits 8*lane+7 : 8*lane) and halfword lane of the access.
    // Big-endian mirrors the lane index: byte 0 lives in bits 31:24.
    logic [1:0] w_byte_lane;
    logic       w_half_lane;
    logic [7:0] w_lanes [4];
    logic [7:0] w_byte;
    logic [15:0] w_half;

    assign w_byte_lane = BIG_ENDIAN ? ~i_addr_lo    : i_addr_lo;
    assign w_half_lane = BIG_ENDIAN ? ~i_addr_lo[1] : i_addr_lo[1];

    for (genvar gi = 0; gi < 4; gi++) begin : g_split
        assign w_lanes[gi] = i_word[8*gi +: 8];
    end

    assign w_byte = w_lanes[w_byte_lane];
    assign w_half = w_half_lane ? i_word[31:16] : i_word[15:0];

    // Load path: pick the lane and sign- or zero-extend it to 32 bits
    always_comb begin
        o_load_data = i_word;
        case (i_size)
            SIZE_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SIZE_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
            default:   o_load_data = i_word;
        endcase
    end

    // Store path: each byte lane either keeps the read word or takes store data
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        localparam logic [1:0] LANE = 2'(gi);
        logic       w_lane_en;
        logic [7:0] w_lane_src;

        // Decide whether this lane is overwritten and which store byte feeds it
        always_comb begin
            w_lane_en  = 1'b1;
            w_lane_src = i_wdata[8*gi +: 8];
            case (i_size)
                SIZE_BYTE: begin
                    w_lane_en  = (w_byte_lane == LANE);
                    w_lane_src = i_wdata[7:0];
                end
                SIZE_HALF: begin
                    w_lane_en  = (w_half_lane == LANE[1]);
                    w_lane_src = LANE[0] ? i_wdata[15:8] : i_wdata[7:0];
                end
                default: begin
                    w_lane_en  = 1'b1;
                    w_lane_src = i_wdata[8*gi +: 8];
                end
            endcase
        end

        assign o_merge_data[8*gi +: 8] = w_lane_en ? w_lane_src : i_word[8*gi +: 8];
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store alignment stage between the MEM stage and a word-only DataMem.
// Loads are zero-latency; word stores are single-cycle; subword stores read
// the word, merge, and write it back on the following cycle (one stall).
// Misaligned accesses are flagged and never reach the memory.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [1:0]  i_mem_size,
    input  logic        i_mem_signed,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic        o_misalign,
    output logic        o_dm_rd,
    output logic        o_dm_wr,
    output logic [31:0] o_dm_addr,
    output logic [31:0] o_dm_wdata,
    input  logic [31:0] i_dm_rdata
);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_merge;
    logic [29:0] r_word_addr;

    logic        w_misalign;
    logic        w_subword_store;
    logic [31:0] w_word_addr;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    assign w_word_addr = {i_addr[31:2], 2'b00};
    assign w_misalign  = (i_mem_rd | i_mem_wr) && is_misaligned(i_mem_size, i_addr[1:0]);
    // A store wins over a simultaneous read request
    assign w_subword_store = i_mem_wr && !w_misalign && is_subword(i_mem_size);

    mem_lane_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane_align (
        .i_size       (i_mem_size),
        .i_signed     (i_mem_signed),
        .i_addr_lo    (i_addr[1:0]),
        .i_word       (i_dm_rdata),
        .i_wdata      (i_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // State register; reset abandons any pending merge write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a subword store spends exactly one cycle in MERGE_WR
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     w_state_next = w_subword_store ? ST_MERGE_WR : ST_IDLE;
            ST_MERGE_WR: w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // Capture the merged word and its word address during the read half of a subword store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_merge     <= '0;
            r_word_addr <= '0;
        end else if (r_state == ST_IDLE && w_subword_store) begin
            r_merge     <= w_merge_data;
            r_word_addr <= i_addr[31:2];
        end
    end

    // Outputs: decode the request in IDLE, replay the captured write in MERGE_WR
    always_comb begin
        o_rdata    = '0;
        o_stall    = 1'b0;
        o_misalign = 1'b0;
        o_dm_rd    = 1'b0;
        o_dm_wr    = 1'b0;
        o_dm_addr  = w_word_addr;
        o_dm_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_misalign) begin
                    o_misalign = 1'b1;
                end else if (i_mem_wr) begin
                    if (w_subword_store) begin
                        o_dm_rd = 1'b1;
                        o_stall = 1'b1;
                    end else begin
                        o_dm_wr    = 1'b1;
                        o_dm_wdata = i_wdata;
                    end
                end else if (i_mem_rd) begin
                    o_dm_rd = 1'b1;
                    o_rdata = w_load_data;
                end
            end
            ST_MERGE_WR: begin
                o_dm_wr    = 1'b1;
                o_dm_addr  = {r_word_addr, 2'b00};
                o_dm_wdata = r_merge;
            end
            default: begin
                o_dm_wr = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (little-endian lanes) with a small
// 256-byte word-addressed DataMem model; addresses beyond it read as 0 and
// ignore writes.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_rd, mem_wr, mem_signed;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, dm_addr, dm_wdata, dm_rdata;
    logic        stall, misalign, dm_rd, dm_wr;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    mem_access_unit #(.BIG_ENDIAN(1'b0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_mem_rd     (mem_rd),
        .i_mem_wr     (mem_wr),
        .i_mem_size   (mem_size),
        .i_mem_signed (mem_signed),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_rdata      (rdata),
        .o_stall      (stall),
        .o_misalign   (misalign),
        .o_dm_rd      (dm_rd),
        .o_dm_wr      (dm_wr),
        .o_dm_addr    (dm_addr),
        .o_dm_wdata   (dm_wdata),
        .i_dm_rdata   (dm_rdata)
    );

    // DataMem model: combinational read, write on the rising edge
    assign dm_rdata = (dm_addr < 32'h100) ? mem[dm_addr[7:2]] : 32'h0;
    always @(posedge clk) begin
        if (dm_wr && dm_addr < 32'h100) mem[dm_addr[7:2]] <= dm_wdata;
    end

    // Present a new request just after the rising edge
    task automatic drive(input logic rd, input logic wr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        mem_rd = rd; mem_wr = wr; mem_size = size; mem_signed = sgn; addr = a; wdata = d;
        if (rd | wr)
            $display("txn rd=%0b wr=%0b size=%0d signed=%0b addr=%h wdata=%h", rd, wr, size, sgn, a, d);
    endtask

    // Advance one cycle with the request held (pipeline stalled)
    task automatic hold();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_rd = 0; mem_wr = 0; mem_size = SIZE_WORD; mem_signed = 0; addr = 0; wdata = 0;
        repeat (2) @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b expected 0", stall); end
        total++; if (dm_wr !== 1'b0) begin bad++; $display("FAIL reset_dm_wr: got %b expected 0", dm_wr); end
        total++; if (dm_rd !== 1'b0) begin bad++; $display("FAIL reset_dm_rd: got %b expected 0", dm_rd); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
        total++; if (misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_word_store_load();
        drive(0, 1, SIZE_WORD, 0, 32'h10, 32'h11223344);
        @(negedge clk);
        total++; if (dm_wr !== 1'b1) begin bad++; $display("FAIL sw_dm_wr: got %b expected 1", dm_wr); end
        total++; if (dm_addr !== 32'h10) begin bad++; $display("FAIL sw_dm_addr: got %h expected 00000010", dm_addr); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL sw_stall: got %b expected 0", stall); end
        total++; if (dm_wdata !== 32'h11223344) begin bad++; $display("FAIL sw_dm_wdata: got %h expected 11223344", dm_wdata); end
        drive(1, 0, SIZE_WORD, 0, 32'h10, 32'h0);
        @(negedge clk);
        total++; if (rdata !== 32'h11223344) begin bad++; $display("FAIL lw_rdata: got %h expected 11223344", rdata); end
        total++; if (dm_rd !== 1'b1) begin bad++; $display("FAIL lw_dm_rd: got %b expected 1", dm_rd); end
    endtask

    task automatic test_load_lanes();
        // Over 0x11223344
        logic [31:0] a1 [4] = '{32'h13, 32'h10, 32'h12, 32'h11};
        logic [1:0]  z1 [4] = '{SIZE_BYTE, SIZE_BYTE, SIZE_HALF, SIZE_BYTE};
        logic        s1 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] e1 [4] = '{32'h00000011, 32'h00000044, 32'h00001122, 32'h00000033};
        // Over 0x80FF0000
        logic [31:0] a2 [5] = '{32'h12, 32'h12, 32'h13, 32'h12, 32'h10};
        logic [1:0]  z2 [5] = '{SIZE_HALF, SIZE_HALF, SIZE_BYTE, SIZE_BYTE, SIZE_HALF};
        logic        s2 [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] e2 [5] = '{32'hFFFF80FF, 32'h000080FF, 32'hFFFFFF80, 32'hFFFFFFFF, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, z1[i], s1[i], a1[i], 32'h0);
            @(negedge clk);
            total++;
            if (rdata !== e1[i]) begin bad++; $display("FAIL load_a[%0d]: got %h expected %h", i, rdata, e1[i]); end
        end
        drive(0, 1, SIZE_WORD, 0, 32'h10, 32'h80FF0000);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, z2[i], s2[i], a2[i], 32'h0);
            @(negedge clk);
            total++;
            if (rdata !== e2[i]) begin bad++; $display("FAIL load_b[%0d]: got %h expected %h", i, rdata, e2[i]); end
        end
        drive(0, 1, SIZE_WORD, 0, 32'h10, 32'h11223344);
    endtask

    task automatic test_subword_store();
        drive(0, 1, SIZE_BYTE, 0, 32'h11, 32'hFFFFFFAB);
        @(negedge clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sb_c1_stall: got %b expected 1", stall); end
        total++; if (dm_rd !== 1'b1) begin bad++; $display("FAIL sb_c1_dm_rd: got %b expected 1", dm_rd); end
        total++; if (dm_wr !== 1'b0) begin bad++; $display("FAIL sb_c1_dm_wr: got %b expected 0", dm_wr); end
        hold();
        @(negedge clk);
        total++; if (dm_wr !== 1'b1) begin bad++; $display("FAIL sb_c2_dm_wr: got %b expected 1", dm_wr); end
        total++; if (dm_wdata !== 32'h1122AB44) begin bad++; $display("FAIL sb_c2_wdata: got %h expected 1122ab44", dm_wdata); end
        total++; if (dm_addr !== 32'h10) begin bad++; $display("FAIL sb_c2_addr: got %h expected 00000010", dm_addr); end
        total++; if ({stall, dm_rd} !== 2'b00) begin bad++; $display("FAIL sb_c2_stall_rd: got %b expected 00", {stall, dm_rd}); end
        drive(1, 0, SIZE_WORD, 0, 32'h10, 32'h0);
        @(negedge clk);
        total++; if (rdata !== 32'h1122AB44) begin bad++; $display("FAIL sb_readback: got %h expected 1122ab44", rdata); end
    endtask

    task automatic test_misalign();
        drive(0, 1, SIZE_HALF, 0, 32'h11, 32'h0000BEEF);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (misalign !== 1'b1) begin bad++; $display("FAIL sh_mis_flag[%0d]: got %b expected 1", c, misalign); end
            total++; if ({dm_wr, dm_rd, stall} !== 3'b000) begin bad++; $display("FAIL sh_mis_quiet[%0d]: got %b expected 000", c, {dm_wr, dm_rd, stall}); end
            hold();
        end
        drive(1, 0, SIZE_WORD, 0, 32'h10, 32'h0);
        @(negedge clk);
        total++; if (rdata !== 32'h1122AB44) begin bad++; $display("FAIL sh_mis_mem: got %h expected 1122ab44", rdata); end
        drive(1, 0, SIZE_WORD, 0, 32'h12, 32'h0);
        @(negedge clk);
        total++; if (misalign !== 1'b1) begin bad++; $display("FAIL lw_mis_flag: got %b expected 1", misalign); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL lw_mis_rdata: got %h expected 00000000", rdata); end
        total++; if (dm_rd !== 1'b0) begin bad++; $display("FAIL lw_mis_dm_rd: got %b expected 0", dm_rd); end
    endtask

    task automatic test_priority();
        drive(1, 1, SIZE_WORD, 0, 32'h14, 32'h5A5A5A5A);
        @(negedge clk);
        total++; if ({dm_wr, dm_rd} !== 2'b10) begin bad++; $display("FAIL rw_priority: got wr/rd=%b expected 10", {dm_wr, dm_rd}); end
        drive(1, 0, SIZE_WORD, 0, 32'h14, 32'h0);
        @(negedge clk);
        total++; if (rdata !== 32'h5A5A5A5A) begin bad++; $display("FAIL rw_readback: got %h expected 5a5a5a5a", rdata); end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, SIZE_WORD, 0, 32'h20, 32'hCAFEF00D);
        drive(0, 1, SIZE_HALF, 0, 32'h20, 32'h0000BEEF);
        @(negedge clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rmid_c1_stall: got %b expected 1", stall); end
        // Enters MERGE_WR at this edge; reset arrives before the write edge
        @(posedge clk); #1;
        rst_n = 1'b0;
        mem_rd = 0; mem_wr = 0; addr = 0; wdata = 0;
        #1;
        total++; if ({dm_wr, stall} !== 2'b00) begin bad++; $display("FAIL rmid_outputs: got wr/stall=%b expected 00", {dm_wr, stall}); end
        @(negedge clk);
        total++; if (dm_wr !== 1'b0) begin bad++; $display("FAIL rmid_no_write: got %b expected 0", dm_wr); end
        @(posedge clk); #1 rst_n = 1'b1;
        drive(1, 0, SIZE_WORD, 0, 32'h20, 32'h0);
        @(negedge clk);
        total++; if (rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL rmid_mem: got %h expected cafef00d", rdata); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] st;
        drive(0, 1, SIZE_WORD, 0, 32'h30, 32'hDEADBEEF);
        drive(0, 1, SIZE_BYTE, 0, 32'h30, 32'h00000001);
        @(negedge clk); st[3] = stall;
        hold();
        @(negedge clk); st[2] = stall;
        drive(0, 1, SIZE_BYTE, 0, 32'h31, 32'h00000002);
        @(negedge clk); st[1] = stall;
        hold();
        @(negedge clk); st[0] = stall;
        total++; if (st !== 4'b1010) begin bad++; $display("FAIL b2b_stall: got %b expected 1010", st); end
        drive(1, 0, SIZE_WORD, 0, 32'h30, 32'h0);
        @(negedge clk);
        total++; if (rdata !== 32'hDEAD0201) begin bad++; $display("FAIL b2b_word: got %h expected dead0201", rdata); end
    endtask

    task automatic test_out_of_range();
        drive(0, 1, SIZE_BYTE, 0, 32'h1001, 32'h000000AB);
        @(negedge clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL oor_stall: got %b expected 1", stall); end
        hold();
        @(negedge clk);
        total++; if (dm_wdata !== 32'h0000AB00) begin bad++; $display("FAIL oor_wdata: got %h expected 0000ab00", dm_wdata); end
        total++; if (dm_addr !== 32'h1000) begin bad++; $display("FAIL oor_addr: got %h expected 00001000", dm_addr); end
        drive(0, 0, SIZE_WORD, 0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_word_store_load();
        test_load_lanes();
        test_subword_store();
        test_misalign();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
